// File: rtl/axis_uart_pkg.sv
// Shared types and helpers for the AXI-stream UART blocks.
// Holds the FSM state encoding, counter-width helper and frame-length function.
package axis_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  // Width of a counter spanning 0..n-1, never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int frame_len(input int data_width, input int stop_bits,
                                   input int clock_div, input bit parity_en);
    return (1 + data_width + stop_bits + (parity_en ? 1 : 0)) * clock_div;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period divider: counts 0..CLOCK_DIV-1 and flags the last cycle of each bit.
// Shared between the UART transmit path and a future receive path.
module uart_bit_timer
  import axis_uart_pkg::*;
#(
  parameter int CLOCK_DIV = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic bit_end
);

  localparam int CW = cnt_width(CLOCK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLOCK_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      count <= '0;
    else if (restart || bit_end)
      count <= '0;
    else
      count <= count + 1'b1;
  end

  assign bit_end = (count == LAST);

endmodule

// File: rtl/axis_uart_tx.sv
// AXI-stream sink that serialises each word as start bit, LSB-first data, stop bits.
// Define AXIS_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module axis_uart_tx
  import axis_uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLOCK_DIV  = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] idata,
  input  logic                  ivalid,
  output logic                  iready,
  output logic                  txd,
  output logic                  busy
);

  localparam int DBW = cnt_width(DATA_WIDTH);
  localparam int SBW = $clog2(STOP_BITS) + 1;
  localparam int BW  = (DBW > SBW) ? DBW : SBW;
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_state_t           state, state_nxt;
  logic [DATA_WIDTH-1:0] shift_q, shift_nxt;
  logic [BW-1:0]         bitcnt_q, bitcnt_nxt;
  logic                  txd_nxt;
  logic                  started;
  logic                  bit_end;
  logic                  restart;
  logic                  accept;
  logic                  last_stop;

  assign last_stop = (bitcnt_q == LAST_STOP);
  // started keeps iready low for the first cycle after reset release
  assign iready    = started && ((state == IDLE) || (state == STOP && bit_end && last_stop));
  assign accept    = ivalid && iready;
  assign restart   = (state == IDLE) || (state_nxt != state);

  uart_bit_timer #(.CLOCK_DIV(CLOCK_DIV)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .restart (restart),
    .bit_end (bit_end)
  );

`ifdef AXIS_UART_TX_PARITY_EN
  logic parity_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      parity_q <= 1'b0;
    else if (accept)
      parity_q <= ^idata;
  end
`endif

  always_comb begin
    state_nxt  = state;
    shift_nxt  = shift_q;
    bitcnt_nxt = bitcnt_q;
    txd_nxt    = txd;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = START;
          shift_nxt = idata;
          txd_nxt   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt  = DATA;
          bitcnt_nxt = '0;
          txd_nxt    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_nxt = shift_q >> 1;
          if (bitcnt_q == LAST_DATA) begin
            bitcnt_nxt = '0;
`ifdef AXIS_UART_TX_PARITY_EN
            state_nxt  = PARITY;
            txd_nxt    = parity_q;
`else
            state_nxt  = STOP;
            txd_nxt    = 1'b1;
`endif
          end else begin
            bitcnt_nxt = bitcnt_q + 1'b1;
            txd_nxt    = shift_nxt[0];
          end
        end
      end
`ifdef AXIS_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_nxt  = STOP;
          bitcnt_nxt = '0;
          txd_nxt    = 1'b1;
        end
      end
`endif
      STOP: begin
        // Accepting in the final stop cycle chains straight into the next start bit
        if (bit_end) begin
          if (!last_stop) begin
            bitcnt_nxt = bitcnt_q + 1'b1;
          end else if (accept) begin
            state_nxt  = START;
            shift_nxt  = idata;
            bitcnt_nxt = '0;
            txd_nxt    = 1'b0;
          end else begin
            state_nxt  = IDLE;
            bitcnt_nxt = '0;
            txd_nxt    = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        txd_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      shift_q  <= '0;
      bitcnt_q <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      started  <= 1'b0;
    end else begin
      state    <= state_nxt;
      shift_q  <= shift_nxt;
      bitcnt_q <= bitcnt_nxt;
      txd      <= txd_nxt;
      busy     <= (state_nxt != IDLE);
      started  <= 1'b1;
    end
  end

`ifdef FORMAL
`ifdef AXIS_UART_TX_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif
  int unsigned frame_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      frame_cnt <= 0;
    else if (state_nxt == START && state != START)
      frame_cnt <= 0;
    else if (state != IDLE)
      frame_cnt <= frame_cnt + 1;
  end

  always @(posedge clock) begin
    if (!reset && state == STOP && bit_end && last_stop)
      assert (frame_cnt == frame_len(DATA_WIDTH, STOP_BITS, CLOCK_DIV, PARITY_ON) - 1);
  end
`endif

endmodule

// File: tb/tb_axis_uart_tx.sv
// Self-checking bench for axis_uart_tx: two instances (div 4 / 1 stop, div 2 / 2 stops)
// checked cycle by cycle against an expected txd waveform queued at each handshake.
module tb_axis_uart_tx;

`ifdef AXIS_UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic [1:0][7:0] idata;
  logic [1:0]      ivalid;
  logic [1:0]      iready;
  logic [1:0]      txd;
  logic [1:0]      busy;

  always #5 clock = ~clock;

  axis_uart_tx #(.DATA_WIDTH(8), .CLOCK_DIV(4), .STOP_BITS(1)) dut0 (
    .clock  (clock),
    .reset  (reset),
    .idata  (idata[0]),
    .ivalid (ivalid[0]),
    .iready (iready[0]),
    .txd    (txd[0]),
    .busy   (busy[0])
  );

  axis_uart_tx #(.DATA_WIDTH(8), .CLOCK_DIV(2), .STOP_BITS(2)) dut1 (
    .clock  (clock),
    .reset  (reset),
    .idata  (idata[1]),
    .ivalid (ivalid[1]),
    .iready (iready[1]),
    .txd    (txd[1]),
    .busy   (busy[1])
  );

  typedef struct {
    int         inst;
    logic [7:0] data;
    bit         par;
    bit         keep;
  } vec_t;

  vec_t       vecs [8];
  bit         expq [2][$];
  int         assertCount = 0;
  int         failCount   = 0;
  bit         readyOk     = 1'b0;
  bit   [1:0] accepted    = '0;
  bit   [1:0] parNext     = '0;

  function automatic int divOf(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic int stopsOf(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  task automatic checkVal(input string name, input int i, input logic act, input logic exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s inst%0d t=%0t: got %b, expected %b", name, i, $time, act, exp);
    end
  endtask

  task automatic pushFrame(input int i, input logic [7:0] d, input bit p);
    for (int k = 0; k < divOf(i); k++) expq[i].push_back(1'b0);
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < divOf(i); k++) expq[i].push_back(d[b]);
    if (PAR_EN)
      for (int k = 0; k < divOf(i); k++) expq[i].push_back(p);
    for (int k = 0; k < stopsOf(i) * divOf(i); k++) expq[i].push_back(1'b1);
  endtask

  // Compares one cycle of each instance against the queued waveform, then records handshakes
  task automatic checkOutput();
    bit expReady;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        checkVal("reset_txd", i, txd[i], 1'b1);
        checkVal("reset_busy", i, busy[i], 1'b0);
        checkVal("reset_iready", i, iready[i], 1'b0);
        expq[i].delete();
      end else begin
        expReady = readyOk && (expq[i].size() <= 1);
        checkVal("iready", i, iready[i], expReady);
        if (expq[i].size() > 0) begin
          checkVal("txd", i, txd[i], expq[i].pop_front());
          checkVal("busy", i, busy[i], 1'b1);
        end else begin
          checkVal("idle_txd", i, txd[i], 1'b1);
          checkVal("idle_busy", i, busy[i], 1'b0);
        end
        if (ivalid[i] && expReady) begin
          pushFrame(i, idata[i], parNext[i]);
          accepted[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clock);
    checkOutput();
    @(posedge clock);
    readyOk = !reset;
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    parNext[v.inst]  = v.par;
    idata[v.inst]    = v.data;
    ivalid[v.inst]   = 1'b1;
    accepted[v.inst] = 1'b0;
    for (int n = 0; n < 300 && !accepted[v.inst]; n++) step();
    checkVal("accept_timeout", v.inst, accepted[v.inst], 1'b1);
    if (!v.keep) begin
      ivalid[v.inst] = 1'b0;
      idata[v.inst]  = 8'($urandom);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 600 && (expq[0].size() > 0 || expq[1].size() > 0); n++) step();
    checkVal("drain_timeout", 0, (expq[0].size() == 0 && expq[1].size() == 0), 1'b1);
    repeat (3) step();
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{inst: 0, data: 8'hA5, par: 1'b0, keep: 1'b0};
    vecs[1] = '{inst: 0, data: 8'h00, par: 1'b0, keep: 1'b1};
    vecs[2] = '{inst: 0, data: 8'hFF, par: 1'b0, keep: 1'b0};
    vecs[3] = '{inst: 0, data: 8'h07, par: 1'b1, keep: 1'b0};
    vecs[4] = '{inst: 0, data: 8'h01, par: 1'b1, keep: 1'b0};
    vecs[5] = '{inst: 1, data: 8'h55, par: 1'b0, keep: 1'b1};
    vecs[6] = '{inst: 1, data: 8'h55, par: 1'b0, keep: 1'b0};
    vecs[7] = '{inst: 1, data: 8'h80, par: 1'b1, keep: 1'b0};

    reset  = 1'b1;
    ivalid = '0;
    idata  = '0;
    repeat (3) step();
    reset = 1'b0;

    // Long idle with idata churning under ivalid low
    for (int n = 0; n < 100; n++) begin
      idata[0] = 8'($urandom);
      idata[1] = 8'($urandom);
      step();
    end

    for (int t = 0; t < 8; t++) applyStimulus(vecs[t]);
    drain();

    // Abort a 0x3C frame mid-flight with an asynchronous reset
    v = '{inst: 0, data: 8'h3C, par: 1'b0, keep: 1'b0};
    applyStimulus(v);
    repeat (14) step();
    reset = 1'b1;
    #1;
    checkVal("async_txd", 0, txd[0], 1'b1);
    checkVal("async_busy", 0, busy[0], 1'b0);
    checkVal("async_iready", 0, iready[0], 1'b0);
    repeat (2) step();
    reset = 1'b0;
    repeat (2) step();
    v = '{inst: 0, data: 8'h81, par: 1'b0, keep: 1'b0};
    applyStimulus(v);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/axis_uart_tx.md
Name: axis_uart_tx

Overview:
AXI-stream sink that serializes each accepted word onto an asynchronous serial line: 1 start bit, DATA_WIDTH data bits LSB first, then stop bits.
It is the consumer end of the stream protocol. It sits directly on a stream FIFO's output port (odata/ovalid/oready) and drains it to an off-chip UART pin.
It uses a single clock domain and has no receive path.

Parameters:
DATA_WIDTH, 8, bits per serial character (1..16)
CLOCK_DIV, 16, clock cycles per serial bit; must be >= 2
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clock  input  1  system clock; all state changes on its rising edge
reset  input  1  asynchronous, active-high reset
idata  input  DATA_WIDTH  stream data word
ivalid  input  1  stream valid
iready  output  1  stream ready; the word transfers on a clock edge where ivalid && iready
txd  output  1  serial line, idle high
busy  output  1  high while a frame is being shifted out

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - While reset is high: state=IDLE, txd=1, busy=0, iready=0, and all counters are 0.
  - iready rises the first cycle after reset is released.
  - Reset mid-frame aborts the frame immediately and drives txd high; the partial character is lost.
- States: IDLE, START, DATA, PARITY (only when the optional feature is compiled in), STOP.
- Bit timer:
  - A divide counter of width $clog2(CLOCK_DIV) counts 0..CLOCK_DIV-1.
  - It is cleared on entry to each state.
  - bit_end is asserted when the counter equals CLOCK_DIV-1.
- Bit counter: $clog2(DATA_WIDTH) bits in DATA, $clog2(STOP_BITS)+1 bits in STOP.
- iready is combinational: iready = (state==IDLE) || (state==STOP && bit_end && last stop bit). It never depends on ivalid.
- Acceptance (ivalid && iready):
  - Latches idata into the shift register.
  - Next state is START with txd=0 from the following cycle.
  - Acceptance in the final stop cycle gives back-to-back frames with no idle gap.
- Transitions:
  - START -> DATA after CLOCK_DIV cycles.
  - DATA: txd = shift[0]. On each bit_end the register shifts right and the bit counter increments. After DATA_WIDTH bits the next state is STOP (or PARITY if enabled).
  - STOP: txd=1 for STOP_BITS*CLOCK_DIV cycles. At the end the next state is START if a word was accepted, otherwise IDLE.
- Frame length is exactly (1+DATA_WIDTH+STOP_BITS)*CLOCK_DIV cycles, plus CLOCK_DIV if parity is enabled.
- txd is a registered output, glitch-free, and changes only at bit boundaries.
- busy = (state != IDLE), registered.
- While ivalid is low in IDLE, the block stays idle with txd=1 indefinitely.
- idata and ivalid may change freely when iready=0. The block samples them only on the handshake edge.

Optional Feature:
Macro AXIS_UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - It lasts CLOCK_DIV cycles with txd = even parity (XOR of all DATA_WIDTH bits of the latched word).
  - The parity is computed at acceptance and stored in a 1-bit register.
- Undefined: no PARITY state and no parity register; DATA goes directly to STOP.
- Under FORMAL, a frame-length assertion accounts for the extra bit.

Decomposition:
- Shared package axis_uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - constant widths derived via $clog2
  - a frame-length function taking DATA_WIDTH, STOP_BITS, CLOCK_DIV and the parity flag
- One natural sub-module, uart_bit_timer:
  - divide counter with restart input and bit_end output
  - reusable by a future axis_uart_rx

Test Plan:
1. Reset, then DATA_WIDTH=8, CLOCK_DIV=4, STOP_BITS=1; send 0xA5 -> iready drops the cycle after accept.
   - txd is 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles.
   - busy is high for 40 cycles, then iready=1.
2. ivalid held high with 0x00 then 0xFF -> second word accepted in cycle 40 (last stop cycle).
   - Second start bit begins at cycle 41; no idle cycle between frames.
3. ivalid low for 100 cycles after reset -> txd=1, busy=0, iready=1 throughout.
   - Toggling idata while ivalid is low has no effect.
4. Assert reset at cycle 15 of a 0x3C frame -> txd=1 and busy=0 immediately (asynchronous); iready=1 the cycle after release.
   - A new word 0x81 then transmits a complete, correct frame.
5. With AXIS_UART_TX_PARITY_EN: send 0xA5 -> parity bit 0 for 4 cycles before the stop bit, frame is 44 cycles. Send 0x07 -> parity bit 1.
6. STOP_BITS=2, CLOCK_DIV=2: send 0x55 back-to-back twice -> each frame is 22 cycles.
   - txd is high for 4 consecutive cycles between the last data bit and the next start bit.
